// File: rtl/antirrebote_pulso_if.sv
`default_nettype none
// ============================================================================
// Module      : antirrebote_pulso_if
// Description : Button-side signal bundle for the push-button conditioner.
//               slave  - the conditioner (samples btn_in, drives the strobes)
//               master - whoever owns the raw button and consumes the strobes
//   btn_in       raw button level, asynchronous, active-high
//   pulse        one-cycle strobe per accepted press or repeat
//   repeat_pulse high together with pulse only on auto-repeat strobes
//   pressed      debounced button level
// Revision    : 1.0 - initial release
// ============================================================================
interface antirrebote_pulso_if;
  logic btn_in;
  logic pulse;
  logic repeat_pulse;
  logic pressed;

  modport slave (
    input  btn_in,
    output pulse,
    output repeat_pulse,
    output pressed
  );

  modport master (
    output btn_in,
    input  pulse,
    input  repeat_pulse,
    input  pressed
  );
endinterface
`default_nettype wire

// File: rtl/antirrebote_pulso.sv
`default_nettype none
// ============================================================================
// Module      : antirrebote_pulso
// Description : Push-button conditioner. Two-flop synchroniser, debounce in
//               both directions, one single-cycle pulse per accepted press and
//               optional auto-repeat pulses while the button stays held.
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : antirrebote_pulso_if.slave (btn_in in; pulse, repeat_pulse,
//          pressed out, all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module antirrebote_pulso #(
  parameter int DEB       = 4,     // consecutive samples to accept a change
  parameter int HOLD      = 16,    // initial pulse -> first repeat
  parameter int RATE      = 8,     // spacing of later repeats
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  antirrebote_pulso_if.slave bus
);

  localparam int c_rep_max = (HOLD > RATE) ? HOLD : RATE;
  localparam int c_deb_w   = $clog2(DEB + 1);
  localparam int c_rep_w   = $clog2(c_rep_max + 1);

  localparam logic [c_deb_w-1:0] c_deb_one = c_deb_w'(1);
  localparam logic [c_rep_w-1:0] c_rep_one = c_rep_w'(1);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_HELD        = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_s1;
  logic               r_s2;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic [c_rep_w-1:0] r_rep_cnt;
  logic               r_first_done;
  logic               r_pulse;
  logic               r_repeat;
  logic               r_pressed;

  logic w_btn_s;
  logic w_deb_done;
  logic w_rep_hit;
  logic w_rep_can_inc;
  int   w_rep_thr;

  assign w_btn_s = r_s2;

  // The sample being taken now is the (deb_cnt+1)-th identical one.
  assign w_deb_done    = (int'(r_deb_cnt) + 1) >= DEB;
  assign w_rep_thr     = r_first_done ? RATE : HOLD;
  assign w_rep_hit     = REPEAT_EN && ((int'(r_rep_cnt) + 1) >= w_rep_thr);
  // Saturate rather than wrap (only matters when repeats are disabled).
  assign w_rep_can_inc = int'(r_rep_cnt) < c_rep_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_state      <= S_IDLE;
      r_deb_cnt    <= '0;
      r_rep_cnt    <= '0;
      r_first_done <= 1'b0;
      r_pulse      <= 1'b0;
      r_repeat     <= 1'b0;
      r_pressed    <= 1'b0;
    end else begin
      r_s1     <= bus.btn_in;
      r_s2     <= r_s1;
      r_pulse  <= 1'b0;
      r_repeat <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_pressed <= 1'b0;
          if (w_btn_s) begin
            if (DEB == 1) begin
              r_state      <= S_HELD;
              r_pulse      <= 1'b1;
              r_pressed    <= 1'b1;
              r_rep_cnt    <= '0;
              r_first_done <= 1'b0;
              r_deb_cnt    <= '0;
            end else begin
              r_state   <= S_DEB_PRESS;
              r_deb_cnt <= c_deb_one;
            end
          end
        end

        S_DEB_PRESS: begin
          if (!w_btn_s) begin
            r_state   <= S_IDLE;
            r_deb_cnt <= '0;
          end else if (w_deb_done) begin
            r_state      <= S_HELD;
            r_pulse      <= 1'b1;
            r_pressed    <= 1'b1;
            r_rep_cnt    <= '0;
            r_first_done <= 1'b0;
            r_deb_cnt    <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_deb_one;
          end
        end

        S_HELD: begin
          r_pressed <= 1'b1;
          // The repeat timer runs on every HELD cycle, including the one
          // that first sees the button drop; only DEB_RELEASE freezes it.
          if (w_rep_hit) begin
            r_pulse      <= 1'b1;
            r_repeat     <= 1'b1;
            r_rep_cnt    <= '0;
            r_first_done <= 1'b1;
          end else if (w_rep_can_inc) begin
            r_rep_cnt <= r_rep_cnt + c_rep_one;
          end
          if (!w_btn_s) begin
            if (DEB == 1) begin
              r_state   <= S_IDLE;
              r_pressed <= 1'b0;
              r_deb_cnt <= '0;
            end else begin
              r_state   <= S_DEB_RELEASE;
              r_deb_cnt <= c_deb_one;
            end
          end
        end

        S_DEB_RELEASE: begin
          r_pressed <= 1'b1;
          if (w_btn_s) begin
            r_state   <= S_HELD;
            r_deb_cnt <= '0;
          end else if (w_deb_done) begin
            r_state   <= S_IDLE;
            r_pressed <= 1'b0;
            r_deb_cnt <= '0;
          end else begin
            r_deb_cnt <= r_deb_cnt + c_deb_one;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_deb_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.pulse        = r_pulse;
  assign bus.repeat_pulse = r_repeat;
  assign bus.pressed      = r_pressed;

endmodule
`default_nettype wire

// File: tb/tb_antirrebote_pulso.sv
`default_nettype none
// ============================================================================
// Module      : tb_antirrebote_pulso
// Description : Self-checking bench for antirrebote_pulso. Two instances share
//               one button: one with auto-repeat, one without. A behavioural
//               model (run-length debounce plus a hold-time timer) is checked
//               on every cycle, and directed scenarios pin literal timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_antirrebote_pulso;
  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int RATE = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn = 1'b0;

  always #5 clk = ~clk;

  antirrebote_pulso_if bus_rep ();
  antirrebote_pulso_if bus_one ();

  assign bus_rep.btn_in = btn;
  assign bus_one.btn_in = btn;

  antirrebote_pulso #(.DEB(DEB), .HOLD(HOLD), .RATE(RATE), .REPEAT_EN(1'b1)) dut_rep (
    .clk(clk),
    .rst(rst),
    .bus(bus_rep)
  );

  antirrebote_pulso #(.DEB(DEB), .HOLD(HOLD), .RATE(RATE), .REPEAT_EN(1'b0)) dut_one (
    .clk(clk),
    .rst(rst),
    .bus(bus_one)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_one = 0;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The accepted level flips once DEB consecutive samples disagree with it.
  // While the level is "pressed" and no contrary sample is pending, a hold
  // timer advances; it fires at HOLD, then every RATE.
  logic m_d1 = 1'b0;
  logic m_d2 = 1'b0;
  logic m_pressed [2];
  logic m_pulse   [2];
  logic m_rep     [2];
  logic m_first   [2];
  int   m_run     [2];
  int   m_elapsed [2];
  bit   checking = 1'b0;

  always @(posedge clk) begin
    logic smp;
    smp = m_d2;
    if (rst) begin
      m_d1 = 1'b0;
      m_d2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_pressed[k] = 1'b0; m_pulse[k] = 1'b0; m_rep[k] = 1'b0;
        m_first[k] = 1'b0;   m_run[k] = 0;      m_elapsed[k] = 0;
      end
      checking = 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_pulse[k] = 1'b0;
        m_rep[k]   = 1'b0;
        if (m_pressed[k] && m_run[k] == 0) begin
          if (k == 0 && m_elapsed[k] + 1 >= (m_first[k] ? RATE : HOLD)) begin
            m_pulse[k]   = 1'b1;
            m_rep[k]     = 1'b1;
            m_elapsed[k] = 0;
            m_first[k]   = 1'b1;
          end else begin
            m_elapsed[k]++;
          end
        end
        if (smp != m_pressed[k]) m_run[k]++;
        else                     m_run[k] = 0;
        if (m_run[k] >= DEB) begin
          m_pressed[k] = ~m_pressed[k];
          m_run[k]     = 0;
          if (m_pressed[k]) begin
            m_pulse[k]   = 1'b1;
            m_elapsed[k] = 0;
            m_first[k]   = 1'b0;
          end
        end
      end
      m_d2 = m_d1;
      m_d1 = btn;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("mdl_rep_pulse",   bus_rep.pulse,        m_pulse[0]);
      chk("mdl_rep_repeat",  bus_rep.repeat_pulse, m_rep[0]);
      chk("mdl_rep_pressed", bus_rep.pressed,      m_pressed[0]);
      chk("mdl_one_pulse",   bus_one.pulse,        m_pulse[1]);
      chk("mdl_one_repeat",  bus_one.repeat_pulse, m_rep[1]);
      chk("mdl_one_pressed", bus_one.pressed,      m_pressed[1]);
      if (bus_one.pulse === 1'b1) n_one++;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit_rep(input string nm, input logic p, input logic r, input logic pr);
    chk({nm, "_rep_pulse"},   bus_rep.pulse,        p);
    chk({nm, "_rep_repeat"},  bus_rep.repeat_pulse, r);
    chk({nm, "_rep_pressed"}, bus_rep.pressed,      pr);
  endtask

  task automatic lit_one(input string nm, input logic p, input logic r, input logic pr);
    chk({nm, "_one_pulse"},   bus_one.pulse,        p);
    chk({nm, "_one_repeat"},  bus_one.repeat_pulse, r);
    chk({nm, "_one_pressed"}, bus_one.pressed,      pr);
  endtask

  logic pat [8];

  initial begin
    int cyc;
    int len;

    // Reset with the button held
    rst = 1'b1; btn = 1'b1;
    step(1); lit_rep("reset1", 0, 0, 0); lit_one("reset1", 0, 0, 0);
    step(1); lit_rep("reset2", 0, 0, 0); lit_one("reset2", 0, 0, 0);
    rst = 1'b0; btn = 1'b0;
    step(8);

    // Clean press, auto-repeat schedule, single pulse without repeat
    n_one = 0;
    btn = 1'b1;                                         // E0 = next edge
    step(5);  lit_rep("press_e4", 0, 0, 0);
    step(1);  lit_rep("press_e5", 1, 0, 1); lit_one("press_e5", 1, 0, 1);
    step(1);  lit_rep("press_e6", 0, 0, 1); lit_one("press_e6", 0, 0, 1);
    step(15); lit_rep("rep_e21", 1, 1, 1);  lit_one("rep_e21", 0, 0, 1);
    step(8);  lit_rep("rep_e29", 1, 1, 1);
    step(8);  lit_rep("rep_e37", 1, 1, 1);
    step(3);  chk_int("one_pulse_total", n_one, 1);

    // Two-cycle release glitch delays the next repeat from E0+45 to E0+47
    btn = 1'b0;
    step(2);
    btn = 1'b1;
    step(3);  lit_rep("glitch_e45", 0, 0, 1);
    step(1);  lit_rep("glitch_e46", 0, 0, 1);
    step(1);  lit_rep("glitch_e47", 1, 1, 1);

    // Release: pressed drops after E1+5, no pulse
    btn = 1'b0;                                         // E1 = next edge
    step(5);  lit_rep("rel_e4", 0, 0, 1);
    step(1);  lit_rep("rel_e5", 0, 0, 0); lit_one("rel_e5", 0, 0, 0);
    step(10);

    // Press bounce: 1,1,1,0 then a clean run
    pat[0] = 1; pat[1] = 1; pat[2] = 1; pat[3] = 0;
    pat[4] = 1; pat[5] = 1; pat[6] = 1; pat[7] = 1;
    for (int i = 0; i < 8; i++) begin
      btn = pat[i];
      step(1);
    end
    // now after F+3, F being the edge that sampled pat[4]
    step(1);  lit_one("bounce_f4", 0, 0, 0);
    step(1);  lit_one("bounce_f5", 1, 0, 1);
    btn = 1'b0;
    step(12);

    // Reset coinciding with debounce completion, then re-debounce
    btn = 1'b1;
    step(5);
    rst = 1'b1;
    step(1);  lit_rep("rst_win", 0, 0, 0); lit_one("rst_win", 0, 0, 0);
    rst = 1'b0;                                         // R1 = next edge
    step(5);  lit_rep("redeb_r4", 0, 0, 0);
    step(1);  lit_rep("redeb_r5", 1, 0, 1);

    // Reset while held
    step(20);
    rst = 1'b1;
    step(1);  lit_rep("rst_held", 0, 0, 0);
    rst = 1'b0;
    step(5);  lit_rep("held_r4", 0, 0, 0);
    step(1);  lit_rep("held_r5", 1, 0, 1);
    btn = 1'b0;
    step(10);

    // Randomised bursts, glitches and occasional resets
    cyc = 0;
    while (cyc < 4000) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 4);
      else                           len = $urandom_range(5, 60);
      for (int j = 0; j < len; j++) begin
        rst = ($urandom_range(0, 299) == 0);
        step(1);
      end
      cyc += len;
    end
    rst = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
